n_one_mux_scan: RTL and testbench

- Parametrised N:1 multiplexer with a registered output. It is the successor to the combinational 2:1 mux.
- Two modes:
  - Manual: an external selector picks the channel.
  - Scan: an internal dwell counter steps through every channel in round-robin order.
- Sits between multi-channel sources (switch banks, sensor lanes) and a single downstream consumer such as a display driver or logger.

---
 rtl/n_one_mux_scan.sv | 119 +++++++++++
 tb/tb_n_one_mux_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/n_one_mux_scan.sv
// N:1 multiplexer with registered output; manual channel select or round-robin
// scan with a per-channel dwell counter, hold, and a wrap pulse.
module n_one_mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] data_in,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      sel_err,
  output logic                      wrap
);

  // state   | meaning
  // IDLE    | first cycle after reset; outputs held at reset values
  // MANUAL  | out follows data_in[selector]
  // SCAN    | out follows data_in[scan channel], channel steps every DWELL cycles
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0]   CH_LIM     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

  state_t           state_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             wrap_pend_q;
  logic [WIDTH-1:0] out_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             out_valid_q, sel_err_q, wrap_q;

  logic [WIDTH-1:0] man_data, scan_data;
  logic             man_legal, adv;

  always_comb begin
    man_data  = '0;
    scan_data = '0;
    // Out-of-range selector matches no channel, so the data stays zero.
    for (int k = 0; k < CHANNELS; k++) begin
      if (selector == SEL_W'(k)) man_data  = data_in[k*WIDTH +: WIDTH];
      if (ch_q == SEL_W'(k))     scan_data = data_in[k*WIDTH +: WIDTH];
    end
    man_legal = {1'b0, selector} < CH_LIM;
    adv       = (cnt_q == DWELL_LAST) && !hold;
    cnt_d     = adv ? 8'd0 : (hold ? cnt_q : cnt_q + 8'd1);
    ch_d      = ch_q;
    if (adv) ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
  end

  // wrap_pend marks an advance out of the last channel so that the wrap pulse
  // lines up with the cycle in which out_sel first shows channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      wrap_pend_q <= 1'b0;
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q       <= '0;
          out_sel_q   <= '0;
          out_valid_q <= 1'b0;
          sel_err_q   <= 1'b0;
          wrap_q      <= 1'b0;
          wrap_pend_q <= 1'b0;
          cnt_q       <= '0;
          ch_q        <= '0;
          state_q     <= mode ? SCAN : MANUAL;
        end
        MANUAL: begin
          out_q       <= man_data;
          out_sel_q   <= selector;
          out_valid_q <= man_legal;
          sel_err_q   <= !man_legal;
          wrap_q      <= 1'b0;
          wrap_pend_q <= 1'b0;
          if (mode) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            ch_q    <= '0;
          end
        end
        SCAN: begin
          out_q       <= scan_data;
          out_sel_q   <= ch_q;
          out_valid_q <= 1'b1;
          sel_err_q   <= 1'b0;
          wrap_q      <= wrap_pend_q;
          wrap_pend_q <= adv && (ch_q == LAST_CH);
          cnt_q       <= cnt_d;
          ch_q        <= ch_d;
          if (!mode) state_q <= MANUAL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_n_one_mux_scan.sv
// Scoreboard bench for n_one_mux_scan: stimulus pushes expected responses from
// an arithmetic reference model, a monitor pops and compares every cycle.
module tb_n_one_mux_scan;

  localparam int WIDTH = 8;
  localparam int CH    = 3;
  localparam int SEL_W = 2;
  localparam int DW    = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [WIDTH*CH-1:0]   data_in = '0;
  logic [SEL_W-1:0]      selector = '0;
  logic                  mode = 1'b0;
  logic                  hold = 1'b0;
  logic [WIDTH-1:0]      out;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid, sel_err, wrap;

  n_one_mux_scan #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W), .DWELL(DW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
    .mode(mode), .hold(hold), .out(out), .out_sel(out_sel),
    .out_valid(out_valid), .sel_err(sel_err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic [SEL_W-1:0] s;
    logic             v;
    logic             e;
    logic             w;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;

  // Reference model: k counts un-held scan cycles since scan entry, so the
  // scan channel is (k / DWELL) mod CHANNELS.
  bit m_idle = 1'b1;
  bit m_scan = 1'b0;
  bit m_wrap = 1'b0;
  int k = 0;

  task automatic cyc(input bit r, input logic [WIDTH*CH-1:0] d,
                     input logic [SEL_W-1:0] s, input bit m, input bit h);
    exp_t e;
    int   ch;
    int   si;
    @(negedge clk);
    reset = r; data_in = d; selector = s; mode = m; hold = h;
    e  = '0;
    si = int'(s);
    if (r) begin
      m_idle = 1'b1; m_scan = 1'b0; m_wrap = 1'b0; k = 0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_scan = m; m_wrap = 1'b0; k = 0;
    end else if (!m_scan) begin
      if (si < CH) begin
        e.o = d[si*WIDTH +: WIDTH];
        e.v = 1'b1;
      end else begin
        e.e = 1'b1;
      end
      e.s = s;
      m_scan = m; m_wrap = 1'b0; k = 0;
    end else begin
      ch  = (k / DW) % CH;
      e.o = d[ch*WIDTH +: WIDTH];
      e.s = ch[SEL_W-1:0];
      e.v = 1'b1;
      e.w = m_wrap;
      m_wrap = 1'b0;
      if (!h) begin
        k++;
        if (k % (DW*CH) == 0) m_wrap = 1'b1;
      end
      m_scan = m;
    end
    q.push_back(e);
    pushed++;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{o: out, s: out_sel, v: out_valid, e: sel_err, w: wrap};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d out/sel/valid/err/wrap got %h/%0d/%b/%b/%b expected %h/%0d/%b/%b/%b",
                   vectors, a.o, a.s, a.v, a.e, a.w, e.o, e.s, e.v, e.e, e.w);
        end
      end
    end
  end

  function automatic logic [WIDTH*CH-1:0] rnd_data();
    return (WIDTH*CH)'($urandom());
  endfunction

  initial begin : stim
    logic [WIDTH*CH-1:0] d;
    bit m;
    int budget;
    d = {8'hCC, 8'hBB, 8'hAA};
    cyc(1, d, 2'd0, 0, 0);
    cyc(1, d, 2'd0, 0, 0);
    cyc(0, d, 2'd2, 0, 0);
    cyc(0, d, 2'd2, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, rnd_data(), 2'(i % 4), 0, $urandom_range(0, 1));
    cyc(0, rnd_data(), 2'd3, 0, 0);
    cyc(0, rnd_data(), 2'd1, 0, 0);
    // Scan with wrap, then a hold stretch with data changes on the held channel
    for (int i = 0; i < 10; i++) cyc(0, rnd_data(), 2'(i % 4), 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, {8'h00, (i < 2) ? 8'h11 : 8'h22, 8'h00}, 2'd0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, rnd_data(), 2'd0, 1, 0);
    cyc(1, rnd_data(), 2'd0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, rnd_data(), 2'd0, 1, 0);
    cyc(0, rnd_data(), 2'd3, 0, 1);
    cyc(0, rnd_data(), 2'd2, 0, 1);
    m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) m = !m;
      d = rnd_data();
      cyc($urandom_range(0, 49) == 0, d, 2'($urandom_range(0, 3)), m,
          $urandom_range(0, 3) == 0);
    end
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0 || vectors != pushed) begin
      miscompares++;
      $display("FAIL drain got %0d checked expected %0d pushed", vectors, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
